// File: rtl/bound_flasher_pkg.sv
// Shared definitions for the bound flasher and its receive-side lamp monitor.
package bound_flasher_pkg;

  localparam int unsigned MX_LP_DEF = 16;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_RISE = 2'b01,
    DIR_FALL = 2'b10
  } dir_e;

endpackage

// File: rtl/lamp_therm_decode.sv
// Thermometer decode of the lamp bus: legal when the lit lamps are a contiguous run from lamp 0.
module lamp_therm_decode #(
  parameter int unsigned MX_LP = 16,
  parameter int unsigned LVL_W = 5
) (
  input  logic [MX_LP-1:0] lamp_in,
  output logic             legal,
  output logic [LVL_W-1:0] level
);

  logic [MX_LP:0] ext;

  always_comb begin
    ext   = {1'b0, lamp_in};
    // A value of the form 2^n-1 has no bit in common with its successor.
    legal = ((ext & (ext + {{MX_LP{1'b0}}, 1'b1})) == '0);
    level = '0;
    for (int i = 0; i < MX_LP; i++) begin
      level = level + LVL_W'(lamp_in[i]);
    end
  end

endmodule

// File: rtl/bound_lamp_monitor.sv
// Passive lamp-bus monitor: tracks level, ramp direction, turnarounds, sequence completion and
// malformed samples of the bound flasher output.
module bound_lamp_monitor
  import bound_flasher_pkg::*;
#(
  parameter int unsigned MX_LP = MX_LP_DEF,
  parameter int unsigned LVL_W = 5,
  parameter int unsigned QUIET = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MX_LP-1:0] lamp_in,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       dir,
  output logic             turn_pulse,
  output logic [LVL_W-1:0] turn_level,
  output logic [CNT_W-1:0] turn_count,
  output logic             seq_done,
  output logic [CNT_W-1:0] seq_count,
  output logic             err_pattern,
  output logic             err_step
);

  localparam int unsigned QW = $clog2(QUIET + 1);

  logic             legal;
  logic [LVL_W-1:0] lvl;

  lamp_therm_decode #(
    .MX_LP (MX_LP),
    .LVL_W (LVL_W)
  ) u_decode (
    .lamp_in (lamp_in),
    .legal   (legal),
    .level   (lvl)
  );

  dir_e             dir_q, dir_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] turn_level_q, turn_level_d;
  logic [CNT_W-1:0] turn_count_q, turn_count_d;
  logic [CNT_W-1:0] seq_count_q, seq_count_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic             active_q, active_d;
  logic             turn_pulse_q, turn_pulse_d;
  logic             seq_done_q, seq_done_d;
  logic             err_pattern_q, err_pattern_d;
  logic             err_step_q, err_step_d;
  logic [LVL_W-1:0] diff;
  logic [CNT_W-1:0] turn_inc;
  logic             turn;

  always_comb begin
    dir_d         = dir_q;
    level_d       = level_q;
    turn_level_d  = turn_level_q;
    turn_count_d  = turn_count_q;
    seq_count_d   = seq_count_q;
    quiet_d       = quiet_q;
    active_d      = active_q;
    err_pattern_d = err_pattern_q;
    err_step_d    = err_step_q;
    turn_pulse_d  = 1'b0;
    seq_done_d    = 1'b0;
    turn          = 1'b0;
    diff          = (lvl > level_q) ? (lvl - level_q) : (level_q - lvl);
    turn_inc      = (turn_count_q == '1) ? turn_count_q : turn_count_q + CNT_W'(1);

    if (!legal) begin
      err_pattern_d = 1'b1;
    end else begin
      level_d = lvl;
      if (diff > LVL_W'(1)) begin
        err_step_d = 1'b1;
      end
      unique case (dir_q)
        DIR_IDLE: begin
          if (lvl != '0) begin
            dir_d    = DIR_RISE;
            active_d = 1'b1;
            // Short gap inside an active sequence is a valley at zero, not a new sequence.
            if (active_q && (quiet_q < QW'(QUIET))) begin
              turn         = 1'b1;
              turn_level_d = '0;
            end
          end else if (quiet_q < QW'(QUIET)) begin
            quiet_d = quiet_q + QW'(1);
            if ((quiet_d == QW'(QUIET)) && active_q) begin
              seq_done_d   = 1'b1;
              seq_count_d  = (seq_count_q == '1) ? seq_count_q : seq_count_q + CNT_W'(1);
              turn_count_d = '0;
              active_d     = 1'b0;
            end
          end
        end
        DIR_RISE: begin
          if (lvl == '0) begin
            dir_d   = DIR_IDLE;
            quiet_d = '0;
          end else if (lvl < level_q) begin
            dir_d        = DIR_FALL;
            turn         = 1'b1;
            turn_level_d = level_q;
          end
        end
        DIR_FALL: begin
          if (lvl == '0) begin
            dir_d   = DIR_IDLE;
            quiet_d = '0;
          end else if (lvl > level_q) begin
            dir_d        = DIR_RISE;
            turn         = 1'b1;
            turn_level_d = level_q;
          end
        end
        default: dir_d = DIR_IDLE;
      endcase
      if (turn) begin
        turn_pulse_d = 1'b1;
        turn_count_d = turn_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q         <= DIR_IDLE;
      level_q       <= '0;
      turn_level_q  <= '0;
      turn_count_q  <= '0;
      seq_count_q   <= '0;
      quiet_q       <= '0;
      active_q      <= 1'b0;
      turn_pulse_q  <= 1'b0;
      seq_done_q    <= 1'b0;
      err_pattern_q <= 1'b0;
      err_step_q    <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      level_q       <= level_d;
      turn_level_q  <= turn_level_d;
      turn_count_q  <= turn_count_d;
      seq_count_q   <= seq_count_d;
      quiet_q       <= quiet_d;
      active_q      <= active_d;
      turn_pulse_q  <= turn_pulse_d;
      seq_done_q    <= seq_done_d;
      err_pattern_q <= err_pattern_d;
      err_step_q    <= err_step_d;
    end
  end

  assign level       = level_q;
  assign dir         = dir_q;
  assign turn_pulse  = turn_pulse_q;
  assign turn_level  = turn_level_q;
  assign turn_count  = turn_count_q;
  assign seq_done    = seq_done_q;
  assign seq_count   = seq_count_q;
  assign err_pattern = err_pattern_q;
  assign err_step    = err_step_q;

endmodule

// File: tb/tb_bound_lamp_monitor.sv
// Directed flasher scenarios plus randomized lamp traffic, checked each cycle against a level-based model.
module tb_bound_lamp_monitor;

  localparam int QT = 4;
  localparam int CMAX = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lamp_in = '0;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic        turn_pulse;
  logic [4:0]  turn_level;
  logic [7:0]  turn_count;
  logic        seq_done;
  logic [7:0]  seq_count;
  logic        err_pattern;
  logic        err_step;

  bound_lamp_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .lamp_in     (lamp_in),
    .level       (level),
    .dir         (dir),
    .turn_pulse  (turn_pulse),
    .turn_level  (turn_level),
    .turn_count  (turn_count),
    .seq_done    (seq_done),
    .seq_count   (seq_count),
    .err_pattern (err_pattern),
    .err_step    (err_step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: levels as integers, direction 0 idle / 1 rise / 2 fall.
  int m_level, m_dir, m_tl, m_tc, m_sc, m_quiet;
  bit m_tp, m_sd, m_ep, m_es, m_active;

  function automatic logic [15:0] therm(input int n);
    logic [31:0] v;
    v = (32'd1 << n) - 32'd1;
    return v[15:0];
  endfunction

  task automatic model_turn(input int at);
    m_tp = 1;
    m_tl = at;
    if (m_tc < CMAX) m_tc++;
  endtask

  task automatic model_step(input logic [15:0] lamp, input bit r);
    bit legal;
    int l, p;
    m_tp = 0;
    m_sd = 0;
    if (r) begin
      m_level = 0; m_dir = 0; m_tl = 0; m_tc = 0; m_sc = 0; m_quiet = 0;
      m_ep = 0; m_es = 0; m_active = 0;
      return;
    end
    legal = 0;
    l = 0;
    for (int n = 0; n <= 16; n++) if (lamp == therm(n)) begin legal = 1; l = n; end
    if (!legal) begin
      m_ep = 1;
      return;
    end
    p = m_level;
    if (l - p > 1 || p - l > 1) m_es = 1;
    m_level = l;
    case (m_dir)
      0: begin
        if (l > 0) begin
          if (m_active && m_quiet < QT) model_turn(0);
          m_dir = 1;
          m_active = 1;
        end else if (m_quiet < QT) begin
          m_quiet++;
          if (m_quiet == QT && m_active) begin
            m_sd = 1;
            if (m_sc < CMAX) m_sc++;
            m_tc = 0;
            m_active = 0;
          end
        end
      end
      1: begin
        if (l == 0) begin m_dir = 0; m_quiet = 0; end
        else if (l < p) begin m_dir = 2; model_turn(p); end
      end
      default: begin
        if (l == 0) begin m_dir = 0; m_quiet = 0; end
        else if (l > p) begin m_dir = 1; model_turn(p); end
      end
    endcase
  endtask

  int tp_seen, sd_seen;
  int tl_seen[$];

  task automatic step(input logic [15:0] lamp, input bit r);
    lamp_in = lamp;
    rst     = r;
    @(posedge clk);
    model_step(lamp, r);
    #1;
    check("level", level, m_level);
    check("dir", dir, m_dir);
    check("turn_pulse", turn_pulse, m_tp);
    check("turn_level", turn_level, m_tl);
    check("turn_count", turn_count, m_tc);
    check("seq_done", seq_done, m_sd);
    check("seq_count", seq_count, m_sc);
    check("err_pattern", err_pattern, m_ep);
    check("err_step", err_step, m_es);
    check("pulse_excl", turn_pulse & seq_done, 0);
    if (turn_pulse) begin
      tp_seen++;
      tl_seen.push_back(int'(turn_level));
    end
    if (seq_done) sd_seen++;
  endtask

  task automatic ramp(input int a, input int b);
    if (b >= a) for (int i = a + 1; i <= b; i++) step(therm(i), 0);
    else        for (int i = a - 1; i >= b; i--) step(therm(i), 0);
  endtask

  task automatic flasher_run();
    int exp_tl[5] = '{5, 0, 10, 5, 15};
    tp_seen = 0;
    sd_seen = 0;
    tl_seen.delete();
    step(therm(0), 0);
    ramp(0, 5); ramp(5, 0); ramp(0, 10); ramp(10, 5); ramp(5, 15); ramp(15, 0);
    for (int i = 0; i < 4; i++) step(therm(0), 0);
    check("flash_turns", tp_seen, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < tl_seen.size()) check("flash_turn_level", tl_seen[i], exp_tl[i]);
    end
    check("flash_seq_done", sd_seen, 1);
    check("flash_seq_count", seq_count, 1);
    check("flash_turn_count", turn_count, 0);
  endtask

  initial begin
    int cur, r;
    // Reset held with all lamps lit, then the first free-running sample.
    for (int i = 0; i < 3; i++) step(16'hFFFF, 1);
    step(16'hFFFF, 0);
    check("post_reset_level", level, 16);
    check("post_reset_dir", dir, 1);

    step(16'h0000, 1);
    flasher_run();

    // Malformed sample mid ramp.
    step(16'h0000, 1);
    ramp(0, 3);
    step(16'h0005, 0);
    check("bad_pattern_err", err_pattern, 1);
    check("bad_pattern_level", level, 3);
    check("bad_pattern_dir", dir, 1);

    // Legal jump of four levels.
    step(16'h0000, 1);
    ramp(0, 2);
    step(therm(6), 0);
    check("jump_err_step", err_step, 1);
    check("jump_level", level, 6);
    check("jump_pulse", turn_pulse, 0);

    // Short gap at zero is a valley, not a sequence end.
    step(16'h0000, 1);
    ramp(0, 2);
    ramp(2, 0);
    step(therm(0), 0);
    step(therm(0), 0);
    sd_seen = 0;
    step(therm(1), 0);
    check("gap_turn_pulse", turn_pulse, 1);
    check("gap_turn_level", turn_level, 0);
    check("gap_seq_done", sd_seen, 0);

    // Reset mid-ramp, then the full pattern again.
    ramp(1, 7);
    step(therm(8), 1);
    check("midrst_level", level, 0);
    check("midrst_dir", dir, 0);
    check("midrst_counts", {turn_count, seq_count}, 0);
    check("midrst_errs", {err_pattern, err_step}, 0);
    flasher_run();

    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cur = 0;
        step(therm(0), 1);
      end else if (r < 6) begin
        step(16'($urandom), 0);
      end else begin
        if (r < 10) cur = $urandom_range(0, 16);
        else if (r < 20) cur = 0;
        else cur = cur + $urandom_range(0, 2) - 1;
        if (cur < 0) cur = 0;
        if (cur > 16) cur = 16;
        step(therm(cur), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
